// File: rtl/axi_resp_push_arbiter.sv
// ---------------------------------------------------------------------------
// axi_resp_push_arbiter: round-robin B/R push arbiter with burst lock-in,
// beat formatting and buffer occupancy tracking.   Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module axi_resp_push_arbiter #(
  parameter  int DEPTH  = 10,
  parameter  int ID_W   = 4,
  parameter  int DATA_W = 32,
  localparam int CNT_W  = $clog2(DEPTH + 1),
  localparam int WORD_W = DATA_W + ID_W + 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              b_req_valid,
  input  logic [ID_W-1:0]   b_req_id,
  input  logic [1:0]        b_req_resp,
  output logic              b_req_ready,
  input  logic              r_req_valid,
  input  logic [ID_W-1:0]   r_req_id,
  input  logic [DATA_W-1:0] r_req_data,
  input  logic [1:0]        r_req_resp,
  input  logic              r_req_last,
  output logic              r_req_ready,
  output logic              buf_wr_en,
  output logic [WORD_W-1:0] buf_wr_data,
  input  logic              buf_rd_en,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty,
  output logic              grant_r
);

  localparam logic [0:0] S_IDLE    = 1'b0;
  localparam logic [0:0] S_R_BURST = 1'b1;
  localparam logic       GR_B      = 1'b0;
  localparam logic       GR_R      = 1'b1;

  logic [0:0]        state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              wr_en_q;
  logic [WORD_W-1:0] wr_data_q, wr_data_d;

  logic full_w, empty_w, b_hs, r_hs, push, pop;

  assign full_w  = (count_q == CNT_W'(DEPTH));
  assign empty_w = (count_q == '0);

  // Readies look only at registered state, full and the competitor's valid,
  // so they can never depend combinationally on their own valid.
  always_comb begin
    b_req_ready = 1'b0;
    r_req_ready = 1'b0;
    if (!rst && !full_w) begin
      if (state_q == S_IDLE) begin
        b_req_ready = (last_grant_q == GR_R) || !r_req_valid;
        r_req_ready = (last_grant_q == GR_B) || !b_req_valid;
      end else begin
        r_req_ready = 1'b1;
      end
    end
  end

  assign b_hs = b_req_valid & b_req_ready;
  assign r_hs = r_req_valid & r_req_ready;
  assign push = b_hs | r_hs;
  assign pop  = buf_rd_en & !empty_w;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    if (b_hs) begin
      last_grant_d = GR_B;
    end
    if (r_hs) begin
      if (r_req_last) begin
        state_d      = S_IDLE;
        last_grant_d = GR_R;
      end else begin
        state_d = S_R_BURST;
      end
    end
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_comb begin
    wr_data_d = wr_data_q;
    if (r_hs) begin
      wr_data_d = {1'b1, r_req_id, r_req_resp, r_req_last, r_req_data};
    end else if (b_hs) begin
      wr_data_d = {1'b0, b_req_id, b_req_resp, 1'b1, {DATA_W{1'b0}}};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= GR_R;
      count_q      <= '0;
      wr_en_q      <= 1'b0;
      wr_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      count_q      <= count_d;
      wr_en_q      <= push;
      wr_data_q    <= wr_data_d;
    end
  end

  assign buf_wr_en   = wr_en_q;
  assign buf_wr_data = wr_data_q;
  assign count       = count_q;
  assign full        = full_w;
  assign empty       = empty_w;
  assign grant_r     = (state_q == S_R_BURST);

endmodule

`default_nettype wire

// File: tb/tb_axi_resp_push_arbiter.sv
// ---------------------------------------------------------------------------
// tb_axi_resp_push_arbiter: directed stimulus with a scoreboard of expected
// buffer writes checked by an independent monitor.   Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_axi_resp_push_arbiter;

  localparam int DEPTH  = 10;
  localparam int ID_W   = 4;
  localparam int DATA_W = 32;
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int WORD_W = DATA_W + ID_W + 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              b_req_valid;
  logic [ID_W-1:0]   b_req_id;
  logic [1:0]        b_req_resp;
  logic              b_req_ready;
  logic              r_req_valid;
  logic [ID_W-1:0]   r_req_id;
  logic [DATA_W-1:0] r_req_data;
  logic [1:0]        r_req_resp;
  logic              r_req_last;
  logic              r_req_ready;
  logic              buf_wr_en;
  logic [WORD_W-1:0] buf_wr_data;
  logic              buf_rd_en;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              empty;
  logic              grant_r;

  int n_total = 0;
  int n_pass  = 0;
  logic [WORD_W-1:0] exp_q[$];

  always #5 clk = ~clk;

  axi_resp_push_arbiter #(.DEPTH(DEPTH), .ID_W(ID_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .b_req_valid(b_req_valid), .b_req_id(b_req_id), .b_req_resp(b_req_resp),
    .b_req_ready(b_req_ready),
    .r_req_valid(r_req_valid), .r_req_id(r_req_id), .r_req_data(r_req_data),
    .r_req_resp(r_req_resp), .r_req_last(r_req_last), .r_req_ready(r_req_ready),
    .buf_wr_en(buf_wr_en), .buf_wr_data(buf_wr_data), .buf_rd_en(buf_rd_en),
    .count(count), .full(full), .empty(empty), .grant_r(grant_r)
  );

  function automatic logic [WORD_W-1:0] bw(input logic [ID_W-1:0] id, input logic [1:0] resp);
    return {1'b0, id, resp, 1'b1, {DATA_W{1'b0}}};
  endfunction

  function automatic logic [WORD_W-1:0] rw(input logic [ID_W-1:0] id, input logic [1:0] resp,
                                           input logic last, input logic [DATA_W-1:0] data);
    return {1'b1, id, resp, last, data};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n);
    buf_rd_en = 1'b1;
    repeat (n) cyc();
    buf_rd_en = 1'b0;
  endtask

  // Monitor: every buffer write must match the oldest expected word.
  always @(negedge clk) begin
    if (buf_wr_en === 1'b1) begin
      n_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL sb_unexpected: got %0h expected no write", buf_wr_data);
      end else begin
        logic [WORD_W-1:0] e;
        e = exp_q.pop_front();
        if (buf_wr_data === e) n_pass++;
        else $display("FAIL sb_word: got %0h expected %0h", buf_wr_data, e);
      end
    end
  end

  initial begin
    rst = 1'b1; b_req_valid = 1'b0; b_req_id = '0; b_req_resp = '0;
    r_req_valid = 1'b0; r_req_id = '0; r_req_data = '0; r_req_resp = '0;
    r_req_last = 1'b0; buf_rd_en = 1'b0;
    repeat (2) cyc();
    #1;
    chk("rst_b_ready", b_req_ready, 0);
    chk("rst_r_ready", r_req_ready, 0);
    chk("rst_wr_en", buf_wr_en, 0);
    chk("rst_grant_r", grant_r, 0);
    rst = 1'b0;
    repeat (3) cyc();
    chk("idle_count", count, 0);
    chk("idle_empty", empty, 1);
    chk("idle_full", full, 0);
    chk("idle_wr_en", buf_wr_en, 0);

    // First tie after reset goes to B, then round-robin hands the next to R.
    b_req_valid = 1'b1; b_req_id = 4'd5; b_req_resp = 2'd1;
    r_req_valid = 1'b1; r_req_id = 4'd2; r_req_resp = 2'd0; r_req_last = 1'b1;
    r_req_data = 32'hA5A5_0001;
    exp_q.push_back(bw(4'd5, 2'd1));
    exp_q.push_back(rw(4'd2, 2'd0, 1'b1, 32'hA5A5_0001));
    exp_q.push_back(bw(4'd6, 2'd0));
    #1;
    chk("tie_b_ready", b_req_ready, 1);
    chk("tie_r_ready", r_req_ready, 0);
    cyc();
    b_req_id = 4'd6; b_req_resp = 2'd0;
    #1;
    chk("rr_r_ready", r_req_ready, 1);
    chk("rr_b_ready", b_req_ready, 0);
    cyc();
    r_req_valid = 1'b0;
    #1;
    chk("rr_b_ready2", b_req_ready, 1);
    cyc();
    b_req_valid = 1'b0;
    chk("tie_count", count, 3);
    drain(3);
    chk("drain1_count", count, 0);
    chk("drain1_empty", empty, 1);

    // Four-beat read burst; B arrives mid-burst and must wait for RLAST.
    r_req_valid = 1'b1; r_req_id = 4'd3; r_req_resp = 2'd0;
    r_req_last = 1'b0; r_req_data = 32'd100;
    exp_q.push_back(rw(4'd3, 2'd0, 1'b0, 32'd100));
    #1;
    chk("burst_r_ready0", r_req_ready, 1);
    chk("burst_grant0", grant_r, 0);
    for (int k = 1; k < 4; k++) begin
      cyc();
      r_req_data = 32'd100 + 32'(k);
      r_req_last = (k == 3);
      b_req_valid = 1'b1; b_req_id = 4'd7; b_req_resp = 2'd2;
      exp_q.push_back(rw(4'd3, 2'd0, (k == 3), 32'd100 + 32'(k)));
      #1;
      chk("burst_b_blocked", b_req_ready, 0);
      chk("burst_grant_r", grant_r, 1);
      chk("burst_r_ready", r_req_ready, 1);
    end
    cyc();
    r_req_valid = 1'b0; r_req_last = 1'b0;
    exp_q.push_back(bw(4'd7, 2'd2));
    #1;
    chk("post_burst_grant", grant_r, 0);
    chk("post_burst_b_ready", b_req_ready, 1);
    cyc();
    b_req_valid = 1'b0;
    chk("burst_count", count, 5);

    // Simultaneous push and pop at count 5.
    b_req_valid = 1'b1; b_req_id = 4'd1; b_req_resp = 2'd0; buf_rd_en = 1'b1;
    exp_q.push_back(bw(4'd1, 2'd0));
    #1;
    chk("pp_b_ready", b_req_ready, 1);
    cyc();
    b_req_valid = 1'b0; buf_rd_en = 1'b0;
    chk("pp_count", count, 5);
    drain(5);
    chk("drain2_count", count, 0);
    buf_rd_en = 1'b1;
    cyc();
    buf_rd_en = 1'b0;
    chk("pop_empty_count", count, 0);
    chk("pop_empty_empty", empty, 1);

    // Fill to DEPTH, then a single pop re-opens ready one cycle later.
    for (int i = 0; i < DEPTH; i++) begin
      b_req_valid = 1'b1; b_req_id = 4'(i); b_req_resp = 2'd3;
      exp_q.push_back(bw(4'(i), 2'd3));
      cyc();
    end
    b_req_id = 4'd10;
    exp_q.push_back(bw(4'd10, 2'd3));
    #1;
    chk("full_count", count, 10);
    chk("full_flag", full, 1);
    chk("full_b_ready", b_req_ready, 0);
    chk("full_r_ready", r_req_ready, 0);
    buf_rd_en = 1'b1;
    #1;
    chk("full_pop_cycle_b_ready", b_req_ready, 0);
    cyc();
    buf_rd_en = 1'b0;
    chk("after_pop_count", count, 9);
    chk("after_pop_full", full, 0);
    #1;
    chk("after_pop_b_ready", b_req_ready, 1);
    cyc();
    b_req_valid = 1'b0;
    chk("refill_count", count, 10);
    chk("refill_full", full, 1);
    drain(10);
    chk("drain3_count", count, 0);

    // Reset asserted after beat 2 of a burst.
    r_req_valid = 1'b1; r_req_id = 4'd4; r_req_resp = 2'd1;
    r_req_last = 1'b0; r_req_data = 32'd200;
    exp_q.push_back(rw(4'd4, 2'd1, 1'b0, 32'd200));
    cyc();
    r_req_data = 32'd201;
    exp_q.push_back(rw(4'd4, 2'd1, 1'b0, 32'd201));
    cyc();
    r_req_valid = 1'b0;
    chk("mid_burst_grant", grant_r, 1);
    chk("mid_burst_count", count, 2);
    rst = 1'b1;
    cyc();
    chk("mrst_count", count, 0);
    chk("mrst_grant_r", grant_r, 0);
    chk("mrst_empty", empty, 1);
    chk("mrst_wr_en", buf_wr_en, 0);
    rst = 1'b0;
    b_req_valid = 1'b1; b_req_id = 4'd9; b_req_resp = 2'd3;
    exp_q.push_back(bw(4'd9, 2'd3));
    #1;
    chk("mrst_b_ready", b_req_ready, 1);
    cyc();
    b_req_valid = 1'b0;
    chk("mrst_b_count", count, 1);
    drain(1);

    repeat (3) cyc();
    chk("sb_drained", 64'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
